seq_trojan_trigger: RTL and testbench
=====================================

Name: seq_trojan_trigger

Overview:
Parametrised sequential Trojan trigger for the AES datapath. It watches the 128-bit state bus. It fires only after an ordered sequence of NUM_PATTERNS state values has been matched, and only after that complete sequence has occurred MATCH_COUNT times. It sits beside the AES core, and its output drives the Trojan payload enable.

Parameters:
WIDTH, 128, width of the monitored state bus.
NUM_PATTERNS, 2, length of the ordered pattern sequence (1..16).
PATTERNS, {128'hffeeddcc_bbaa9988_77665544_33221100, 128'h00112233_44556677_8899aabb_ccddeeff}, packed NUM_PATTERNS*WIDTH table; pattern k is PATTERNS[k*WIDTH +: WIDTH], so pattern 0 is 128'h00112233_..._ccddeeff.
MATCH_COUNT, 3, number of complete sequences required before firing (1..255).
STICKY, 1, 1 = trigger holds until reset; 0 = one-cycle pulse, then re-arm.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  arm enable; 0 freezes tracking (no state change).
state  input  WIDTH  monitored AES state.
state_valid  input  1  qualifies state for one cycle.
Tj_Trig  output  1  trigger output (registered).
seq_idx  output  $clog2(NUM_PATTERNS+1)  next pattern index expected (debug).
occur_cnt  output  8  completed-sequence count (debug).

Behaviour:
- Reset (async, rst=1): FSM=IDLE, seq_idx=0, occur_cnt=0, Tj_Trig=0. Reset asserted mid-sequence or while FIRED discards all progress.
- A sample is an event only on a clock edge where en=1 and state_valid=1. All other cycles hold all registers.
- Each event compares state against PATTERNS[seq_idx] (full WIDTH equality) and updates seq_idx on the same edge.
- FSM states:
  - IDLE: seq_idx=0, waiting for pattern 0; a match moves to TRACK with seq_idx=1.
  - TRACK: a match increments seq_idx.
  - FIRED: trigger active.
- Sequence completion: a match on index NUM_PATTERNS-1 increments occur_cnt (saturating at 255) and sets seq_idx=0. The FSM then goes to IDLE, or to FIRED if the new occur_cnt == MATCH_COUNT.
- Mismatch in TRACK:
  - if state == PATTERNS[0]: seq_idx=1 (restart credit), stay in TRACK;
  - else seq_idx=0 and go to IDLE.
  - occur_cnt is unaffected either way.
- NUM_PATTERNS=1: every pattern-0 match is a completion, and the FSM never enters TRACK.
- FIRED, STICKY=1: Tj_Trig=1, held until rst; events are ignored.
- FIRED, STICKY=0: Tj_Trig=1 for exactly one cycle. On the next edge the FSM goes to IDLE and clears occur_cnt and seq_idx, regardless of events in that cycle.
- Latency: Tj_Trig rises on the clock edge that captures the final completing sample (registered, 1 cycle after that sample is presented).
- Tj_Trig = (FSM==FIRED) and is registered; there is no combinational path from state.
- Duplicate or repeated valid samples of the same value are separate events. For example, pattern 0 seen twice in TRACK with seq_idx=1 and NUM_PATTERNS>1 counts as a mismatch-with-restart, so seq_idx stays 1.

Decomposition:
- Package trojan_pkg:
  - fsm enum trig_state_t {IDLE, TRACK, FIRED};
  - localparam default pattern constants PAT_A=128'h00112233_44556677_8899aabb_ccddeeff and PAT_B=128'hffeeddcc_bbaa9988_77665544_33221100;
  - OCC_W=8.
- One sub-module, trig_pattern_match: a combinational mux of PATTERNS[seq_idx] plus the equality compare, also providing the pattern-0 compare. It outputs hit_cur and hit_first. The FSM and counters stay in the top level.

Test Plan:
- Defaults, reset then valid PAT_A, PAT_B repeated 3 times -> Tj_Trig=0 after sequences 1 and 2; Tj_Trig=1 the edge after the 6th sample; stays 1 for 20 further cycles (STICKY=1).
- PAT_A, 0, PAT_B -> seq_idx returns to 0 and occur_cnt=0. Then PAT_A, PAT_A, PAT_B -> seq_idx=1 after the second PAT_A and occur_cnt=1 after PAT_B.
- The full trigger sequence with state_valid=0 or en=0 on every sample -> no change: seq_idx=0, occur_cnt=0, Tj_Trig=0. Gaps of idle cycles between valid samples do not break the sequence.
- STICKY=0, MATCH_COUNT=1: PAT_A, PAT_B -> Tj_Trig is high for exactly 1 cycle, then occur_cnt=0. A repeated PAT_A, PAT_B fires a second pulse.
- Assert rst asynchronously (between edges) while in TRACK with occur_cnt=2, and separately while FIRED -> all outputs become 0 immediately. Three fresh sequences are then needed to fire.
- NUM_PATTERNS=1, PATTERNS=PAT_A, MATCH_COUNT=2: two PAT_A samples separated by one unrelated sample -> Tj_Trig=1 after the second PAT_A.

Source files
------------

// File: rtl/trojan_pkg.sv
// Shared types and constants for the sequential Trojan trigger.
package trojan_pkg;

   localparam int unsigned OCC_W = 8;

   localparam logic [127:0] PAT_A = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] PAT_B = 128'hffeeddcc_bbaa9988_77665544_33221100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FIRED = 2'd2
   } trig_state_t;

endpackage

// File: rtl/trig_pattern_match.sv
// Combinational lookup of the expected pattern plus full-width compares
// against it and against pattern 0 (restart credit).
module trig_pattern_match #(
   parameter int unsigned WIDTH        = 128,
   parameter int unsigned NUM_PATTERNS = 2,
   parameter int unsigned IDX_W        = 2,
   parameter logic [NUM_PATTERNS*WIDTH-1:0] PATTERNS = '0
) (
   input  logic [IDX_W-1:0] seq_idx,
   input  logic [WIDTH-1:0] state,
   output logic             hit_cur,
   output logic             hit_first
);

   logic [WIDTH-1:0] cur_pat;

   always_comb begin
      cur_pat = '0;
      for (int k = 0; k < int'(NUM_PATTERNS); k++) begin
         if (seq_idx == IDX_W'(k)) begin
            cur_pat = PATTERNS[k*WIDTH +: WIDTH];
         end
      end
   end

   assign hit_cur   = (state == cur_pat);
   assign hit_first = (state == PATTERNS[WIDTH-1:0]);

endmodule

// File: rtl/seq_trojan_trigger.sv
// Sequential trigger: fires after an ordered pattern sequence on the AES
// state bus has completed MATCH_COUNT times.
module seq_trojan_trigger
   import trojan_pkg::*;
#(
   parameter int unsigned WIDTH        = 128,
   parameter int unsigned NUM_PATTERNS = 2,
   parameter logic [NUM_PATTERNS*WIDTH-1:0] PATTERNS = {PAT_B, PAT_A},
   parameter int unsigned MATCH_COUNT  = 3,
   parameter bit          STICKY       = 1'b1,
   localparam int unsigned IDX_W       = $clog2(NUM_PATTERNS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] state,
   input  logic             state_valid,
   output logic             Tj_Trig,
   output logic [IDX_W-1:0] seq_idx,
   output logic [OCC_W-1:0] occur_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
   localparam logic [OCC_W-1:0] OCC_MAX  = '1;

   trig_state_t      state_q, state_n;
   logic [IDX_W-1:0] seq_q, seq_n;
   logic [OCC_W-1:0] occ_q, occ_n, occ_inc;
   logic             trig_q;
   logic             evt;
   logic             hit_cur, hit_first;

   assign evt = en & state_valid;

   trig_pattern_match #(
      .WIDTH        (WIDTH),
      .NUM_PATTERNS (NUM_PATTERNS),
      .IDX_W        (IDX_W),
      .PATTERNS     (PATTERNS)
   ) u_match (
      .seq_idx   (seq_q),
      .state     (state),
      .hit_cur   (hit_cur),
      .hit_first (hit_first)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         seq_q   <= '0;
         occ_q   <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         seq_q   <= seq_n;
         occ_q   <= occ_n;
         trig_q  <= (state_n == FIRED);
      end
   end

   // Next-state: only qualified samples advance tracking; FIRED either holds or re-arms.
   always_comb begin
      state_n = state_q;
      seq_n   = seq_q;
      occ_n   = occ_q;
      occ_inc = (occ_q == OCC_MAX) ? occ_q : occ_q + OCC_W'(1);
      case (state_q)
         IDLE, TRACK: begin
            if (evt) begin
               if (hit_cur) begin
                  if (seq_q == LAST_IDX) begin
                     occ_n   = occ_inc;
                     seq_n   = '0;
                     state_n = (occ_inc == OCC_W'(MATCH_COUNT)) ? FIRED : IDLE;
                  end else begin
                     seq_n   = seq_q + IDX_W'(1);
                     state_n = TRACK;
                  end
               end else if (state_q == TRACK) begin
                  if (hit_first) begin
                     seq_n = IDX_W'(1);
                  end else begin
                     seq_n   = '0;
                     state_n = IDLE;
                  end
               end
            end
         end
         FIRED: begin
            if (!STICKY) begin
               state_n = IDLE;
               seq_n   = '0;
               occ_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            seq_n   = '0;
            occ_n   = '0;
         end
      endcase
   end

   assign Tj_Trig   = trig_q;
   assign seq_idx   = seq_q;
   assign occur_cnt = occ_q;

endmodule

// File: tb/tb_seq_trojan_trigger.sv
// Directed self-checking bench: table-driven vectors on the default build,
// plus hand sequences for pulse mode, async reset and single-pattern builds.
module tb_seq_trojan_trigger;
   import trojan_pkg::*;

   localparam logic [127:0] PAT_X = 128'h0000_1234_0000_5678_0000_9abc_0000_def0;
   localparam logic [127:0] ZERO  = 128'h0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         state_valid = 1'b0;
   logic [127:0] state = '0;

   logic         d0_trig, d1_trig, d2_trig;
   logic [1:0]   d0_idx, d1_idx;
   logic [0:0]   d2_idx;
   logic [7:0]   d0_occ, d1_occ, d2_occ;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_trojan_trigger u_d0 (
      .clk(clk), .rst(rst), .en(en), .state(state), .state_valid(state_valid),
      .Tj_Trig(d0_trig), .seq_idx(d0_idx), .occur_cnt(d0_occ)
   );

   seq_trojan_trigger #(
      .NUM_PATTERNS(2), .PATTERNS({PAT_B, PAT_A}), .MATCH_COUNT(1), .STICKY(1'b0)
   ) u_d1 (
      .clk(clk), .rst(rst), .en(en), .state(state), .state_valid(state_valid),
      .Tj_Trig(d1_trig), .seq_idx(d1_idx), .occur_cnt(d1_occ)
   );

   seq_trojan_trigger #(
      .NUM_PATTERNS(1), .PATTERNS(PAT_A), .MATCH_COUNT(2), .STICKY(1'b1)
   ) u_d2 (
      .clk(clk), .rst(rst), .en(en), .state(state), .state_valid(state_valid),
      .Tj_Trig(d2_trig), .seq_idx(d2_idx), .occur_cnt(d2_occ)
   );

   typedef struct {
      logic         do_rst;
      logic         e;
      logic         v;
      logic [127:0] s;
      logic         trig;
      logic [1:0]   idx;
      logic [7:0]   occ;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic e, input logic v,
                               input logic [127:0] s, input logic t,
                               input logic [1:0] i, input logic [7:0] o);
      vec_t x;
      x.do_rst = r; x.e = e; x.v = v; x.s = s; x.trig = t; x.idx = i; x.occ = o;
      vecs.push_back(x);
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic e, input logic v, input logic [127:0] s);
      en = e; state_valid = v; state = s;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1; en = 1'b0; state_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_d0(input string name, input logic t, input logic [1:0] i, input logic [7:0] o);
      chk({name, "_trig"}, 32'(d0_trig), 32'(t));
      chk({name, "_idx"},  32'(d0_idx),  32'(i));
      chk({name, "_occ"},  32'(d0_occ),  32'(o));
   endtask

   task automatic chk_d1(input string name, input logic t, input logic [1:0] i, input logic [7:0] o);
      chk({name, "_trig"}, 32'(d1_trig), 32'(t));
      chk({name, "_idx"},  32'(d1_idx),  32'(i));
      chk({name, "_occ"},  32'(d1_occ),  32'(o));
   endtask

   task automatic chk_d2(input string name, input logic t, input logic i, input logic [7:0] o);
      chk({name, "_trig"}, 32'(d2_trig), 32'(t));
      chk({name, "_idx"},  32'(d2_idx),  32'(i));
      chk({name, "_occ"},  32'(d2_occ),  32'(o));
   endtask

   initial begin
      // Full trigger sequence on the default build
      add(1, 0, 0, ZERO,  0, 0, 0);
      add(0, 1, 1, PAT_A, 0, 1, 0);
      add(0, 1, 1, PAT_B, 0, 0, 1);
      add(0, 1, 1, PAT_A, 0, 1, 1);
      add(0, 1, 1, PAT_B, 0, 0, 2);
      add(0, 1, 1, PAT_A, 0, 1, 2);
      add(0, 1, 1, PAT_B, 1, 0, 3);
      add(0, 1, 1, PAT_A, 1, 0, 3);
      // Mismatch drops to IDLE; repeated PAT_A keeps restart credit
      add(1, 0, 0, ZERO,  0, 0, 0);
      add(0, 1, 1, PAT_A, 0, 1, 0);
      add(0, 1, 1, ZERO,  0, 0, 0);
      add(0, 1, 1, PAT_B, 0, 0, 0);
      add(0, 1, 1, PAT_A, 0, 1, 0);
      add(0, 1, 1, PAT_A, 0, 1, 0);
      add(0, 1, 1, PAT_B, 0, 0, 1);
      // Unqualified samples change nothing
      add(1, 0, 0, ZERO,  0, 0, 0);
      for (int r = 0; r < 3; r++) begin
         add(0, 1, 0, PAT_A, 0, 0, 0);
         add(0, 1, 0, PAT_B, 0, 0, 0);
      end
      for (int r = 0; r < 3; r++) begin
         add(0, 0, 1, PAT_A, 0, 0, 0);
         add(0, 0, 1, PAT_B, 0, 0, 0);
      end
      // Idle gaps do not break a sequence
      add(0, 1, 1, PAT_A, 0, 1, 0);
      add(0, 0, 0, PAT_X, 0, 1, 0);
      add(0, 1, 0, ZERO,  0, 1, 0);
      add(0, 1, 1, PAT_B, 0, 0, 1);

      #2;
      foreach (vecs[i]) begin
         if (vecs[i].do_rst) pulse_reset();
         else step(vecs[i].e, vecs[i].v, vecs[i].s);
         chk_d0($sformatf("vec%0d", i), vecs[i].trig, vecs[i].idx, vecs[i].occ);
      end

      // Sticky trigger holds through further activity
      pulse_reset();
      for (int r = 0; r < 3; r++) begin
         step(1, 1, PAT_A);
         step(1, 1, PAT_B);
      end
      chk_d0("sticky_fire", 1, 0, 3);
      for (int c = 0; c < 20; c++) begin
         step(1, 1, (c % 2 == 0) ? PAT_A : PAT_B);
         chk_d0($sformatf("sticky_hold%0d", c), 1, 0, 3);
      end

      // Pulse mode, MATCH_COUNT=1: one-cycle pulse, then re-arm
      pulse_reset();
      step(1, 1, PAT_A); chk_d1("pulse_a1", 0, 1, 0);
      step(1, 1, PAT_B); chk_d1("pulse_b1", 1, 0, 1);
      step(1, 1, PAT_A); chk_d1("pulse_clr1", 0, 0, 0);
      step(1, 1, PAT_B); chk_d1("pulse_idle", 0, 0, 0);
      step(1, 1, PAT_A); chk_d1("pulse_a2", 0, 1, 0);
      step(1, 1, PAT_B); chk_d1("pulse_b2", 1, 0, 1);
      step(0, 0, ZERO);  chk_d1("pulse_clr2", 0, 0, 0);

      // Async reset mid-sequence discards progress
      pulse_reset();
      step(1, 1, PAT_A); step(1, 1, PAT_B);
      step(1, 1, PAT_A); step(1, 1, PAT_B);
      step(1, 1, PAT_A);
      chk_d0("pre_rst_track", 0, 1, 2);
      #2 rst = 1'b1;
      #1 chk_d0("async_rst_track", 0, 0, 0);
      @(posedge clk); #1 rst = 1'b0;
      step(1, 1, PAT_A); step(1, 1, PAT_B);
      step(1, 1, PAT_A); step(1, 1, PAT_B);
      step(1, 1, PAT_A);
      chk_d0("fresh_5", 0, 1, 2);
      step(1, 1, PAT_B);
      chk_d0("fresh_fire", 1, 0, 3);
      #2 rst = 1'b1;
      #1 chk_d0("async_rst_fired", 0, 0, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Single-pattern build, MATCH_COUNT=2
      pulse_reset();
      step(1, 1, PAT_A); chk_d2("np1_a1", 0, 0, 1);
      step(1, 1, PAT_X); chk_d2("np1_x",  0, 0, 1);
      step(1, 1, PAT_A); chk_d2("np1_a2", 1, 0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
